// File: rtl/snake_dir_if.sv
// Bundles the snake direction controller's inputs and outputs: raw buttons and game pulses in,
// the steering direction, press pulse and debounced levels out.
interface snake_dir_if;
    logic       btn_u;
    logic       btn_l;
    logic       btn_d;
    logic       btn_r;
    logic       move_tick;
    logic       game_restart;
    logic [1:0] dir;
    logic       press_pulse;
    logic [3:0] btn_state;

    modport master (
        output btn_u, btn_l, btn_d, btn_r, move_tick, game_restart,
        input  dir, press_pulse, btn_state
    );

    modport slave (
        input  btn_u, btn_l, btn_d, btn_r, move_tick, game_restart,
        output dir, press_pulse, btn_state
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Button conditioning and steering for the snake core: synchronise, debounce, edge-detect,
// then validate turns against the current heading through a 2-entry turn queue.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic       clk,
    input logic       rst,
    snake_dir_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       DIR_LEFT  = 2'b00;
    localparam logic [1:0]       DIR_RIGHT = 2'b01;
    localparam logic [1:0]       DIR_UP    = 2'b10;
    localparam logic [1:0]       DIR_DOWN  = 2'b11;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [3:0]       rise;
    logic [CNT_W-1:0] cnt [4];
    logic             press_q;

    logic [1:0]       dir_q;
    logic [1:0]       q0;
    logic [1:0]       q1;
    logic [1:0]       count;

    logic             cand_valid;
    logic [1:0]       cand;
    logic [1:0]       ref_dir;
    logic             reject;
    logic             pop;
    logic             push;
    logic [1:0]       n_q0;
    logic [1:0]       n_q1;
    logic [1:0]       n_count;

    // Bit order {u,l,d,r} matches btn_state.
    assign raw = {bus.btn_u, bus.btn_l, bus.btn_d, bus.btn_r};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any cycle agreeing with the stable level restarts the count, so bounces never accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable & ~stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= '0;
            press_q  <= 1'b0;
        end else begin
            stable_d <= stable;
            press_q  <= |rise;
        end
    end

    // Simultaneous rises collapse to one candidate, priority U > D > L > R.
    always_comb begin
        cand_valid = |rise;
        cand       = DIR_RIGHT;
        if (rise[3])      cand = DIR_UP;
        else if (rise[1]) cand = DIR_DOWN;
        else if (rise[2]) cand = DIR_LEFT;
        else              cand = DIR_RIGHT;
    end

    // The reference is taken before any same-cycle pop; the fullness check uses the post-pop count.
    always_comb begin
        if (count == 2'd2)      ref_dir = q1;
        else if (count == 2'd1) ref_dir = q0;
        else                    ref_dir = dir_q;

        reject  = (cand == ref_dir) || (cand == {ref_dir[1], ~ref_dir[0]});
        pop     = bus.move_tick && (count != 2'd0);

        n_q0    = q0;
        n_q1    = q1;
        n_count = count;
        if (pop) begin
            n_q0    = q1;
            n_count = count - 2'd1;
        end

        push = cand_valid && !reject && (n_count != 2'd2);
        if (push) begin
            if (n_count == 2'd0) n_q0 = cand;
            else                 n_q1 = cand;
            n_count = n_count + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= DIR_RIGHT;
            q0    <= DIR_RIGHT;
            q1    <= DIR_RIGHT;
            count <= 2'd0;
        end else if (bus.game_restart) begin
            dir_q <= DIR_RIGHT;
            count <= 2'd0;
        end else begin
            if (pop) dir_q <= q0;
            q0    <= n_q0;
            q1    <= n_q1;
            count <= n_count;
        end
    end

    assign bus.dir         = dir_q;
    assign bus.press_pulse = press_q;
    assign bus.btn_state   = stable;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: a queue-based reference model compared every cycle,
// plus literal expectations for latency, press counts and the applied directions.
module tb_snake_dir_ctrl;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int pp_count = 0;
    logic [3:0] cur = 4'b0000;

    snake_dir_if bus ();

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: button pipeline, debounced levels and a queue of pending turns.
    logic [3:0] m_s1, m_s2, m_stable, m_stable_d, m_rise;
    int         m_run [4];
    logic       m_press;
    logic [1:0] m_dir, m_cand, m_ref;
    logic [1:0] m_q [$];
    bit         m_have;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_press = 1'b0;
            m_dir   = 2'b01;
            m_q.delete();
        end else begin
            m_rise     = m_stable & ~m_stable_d;
            m_press    = |m_rise;
            m_stable_d = m_stable;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] !== m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_stable[i] = m_s2[i];
                        m_run[i]    = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {bus.btn_u, bus.btn_l, bus.btn_d, bus.btn_r};

            m_have = 1'b1;
            m_cand = 2'b01;
            if (m_rise[3])      m_cand = 2'b10;
            else if (m_rise[1]) m_cand = 2'b11;
            else if (m_rise[2]) m_cand = 2'b00;
            else if (m_rise[0]) m_cand = 2'b01;
            else                m_have = 1'b0;

            if (bus.game_restart) begin
                m_dir = 2'b01;
                m_q.delete();
            end else begin
                m_ref = (m_q.size() > 0) ? m_q[$] : m_dir;
                if (bus.move_tick && m_q.size() > 0) m_dir = m_q.pop_front();
                if (m_have && m_cand != m_ref && m_cand != opposite(m_ref) && m_q.size() < 2)
                    m_q.push_back(m_cand);
            end
        end
    end

    task automatic check_output(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("model dir", {2'b00, bus.dir}, {2'b00, m_dir});
        check_output("model press_pulse", {3'b000, bus.press_pulse}, {3'b000, m_press});
        check_output("model btn_state", bus.btn_state, m_stable);
        if (bus.press_pulse) pp_count++;
    end

    task automatic apply_stimulus(input logic [3:0] btns, input logic tick, input logic restart);
        {bus.btn_u, bus.btn_l, bus.btn_d, bus.btn_r} = btns;
        bus.move_tick    = tick;
        bus.game_restart = restart;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        apply_stimulus(cur, 1'b1, 1'b0);
        @(negedge clk);
        apply_stimulus(cur, 1'b0, 1'b0);
    endtask

    task automatic pulse_restart();
        apply_stimulus(cur, 1'b0, 1'b1);
        @(negedge clk);
        apply_stimulus(cur, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] mask);
        cur = mask;
        apply_stimulus(cur, 1'b0, 1'b0);
        wait_cycles(10);
        cur = 4'b0000;
        apply_stimulus(cur, 1'b0, 1'b0);
        wait_cycles(10);
    endtask

    // Edges counted from 1 = first posedge after the caller's negedge.
    task automatic measure_up(output int st_edge, output int pp_edge);
        st_edge = 0;
        pp_edge = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (st_edge == 0 && bus.btn_state[3]) st_edge = n;
            if (pp_edge == 0 && bus.press_pulse) pp_edge = n;
        end
        @(negedge clk);
    endtask

    int st_e, pp_e;

    initial begin
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);

        check_output("reset dir", {2'b00, bus.dir}, 4'b0001);
        check_output("reset press_pulse", {3'b000, bus.press_pulse}, 4'b0000);
        check_output("reset btn_state", bus.btn_state, 4'b0000);
        pulse_tick();
        check_output("idle tick dir", {2'b00, bus.dir}, 4'b0001);

        cur = 4'b1000;
        apply_stimulus(cur, 1'b0, 1'b0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check_output("midrun reset btn_state", bus.btn_state, 4'b0000);
        measure_up(st_e, pp_e);
        check_output("post-reset stable latency", 4'(st_e), 4'd6);
        check_output("post-reset press latency", 4'(pp_e), 4'd7);
        cur = 4'b0000;
        apply_stimulus(cur, 1'b0, 1'b0);
        wait_cycles(10);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(2);

        pp_count = 0;
        for (int i = 0; i < 10; i++) begin
            cur = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            apply_stimulus(cur, 1'b0, 1'b0);
            wait_cycles(2);
        end
        check_output("bounce no press", 4'(pp_count), 4'd0);
        cur = 4'b1000;
        apply_stimulus(cur, 1'b0, 1'b0);
        measure_up(st_e, pp_e);
        check_output("bounce stable latency", 4'(st_e), 4'd6);
        check_output("bounce press latency", 4'(pp_e), 4'd7);
        check_output("bounce single press", 4'(pp_count), 4'd1);
        cur = 4'b0000;
        apply_stimulus(cur, 1'b0, 1'b0);
        wait_cycles(10);
        check_output("held before tick dir", {2'b00, bus.dir}, 4'b0001);
        pulse_tick();
        check_output("up applied dir", {2'b00, bus.dir}, 4'b0010);

        pulse_restart();
        check_output("restart dir", {2'b00, bus.dir}, 4'b0001);
        press(4'b0100);
        pulse_tick();
        check_output("reversal rejected dir", {2'b00, bus.dir}, 4'b0001);
        press(4'b0001);
        pulse_tick();
        check_output("same dir rejected", {2'b00, bus.dir}, 4'b0001);

        press(4'b1000);
        press(4'b0100);
        press(4'b0010);
        pulse_tick();
        check_output("queue tick1 dir", {2'b00, bus.dir}, 4'b0010);
        pulse_tick();
        check_output("queue tick2 dir", {2'b00, bus.dir}, 4'b0000);
        pulse_tick();
        check_output("queue tick3 dir", {2'b00, bus.dir}, 4'b0000);

        pp_count = 0;
        press(4'b1001);
        check_output("simultaneous single press", 4'(pp_count), 4'd1);
        pulse_tick();
        check_output("simultaneous U wins dir", {2'b00, bus.dir}, 4'b0010);

        pulse_restart();
        press(4'b1000);
        cur = 4'b0010;
        apply_stimulus(cur, 1'b0, 1'b0);
        wait_cycles(6);
        apply_stimulus(cur, 1'b1, 1'b1);
        @(negedge clk);
        check_output("coincident press_pulse", {3'b000, bus.press_pulse}, 4'b0001);
        apply_stimulus(cur, 1'b0, 1'b0);
        check_output("restart override dir", {2'b00, bus.dir}, 4'b0001);
        cur = 4'b0000;
        apply_stimulus(cur, 1'b0, 1'b0);
        wait_cycles(10);
        pulse_tick();
        check_output("flushed queue tick dir", {2'b00, bus.dir}, 4'b0001);

        wait_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
